// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single data-memory port: CPU load/store (port 0)
// and debug/loader (port 1), sequenced IDLE -> ACCESS -> [WAIT] -> DONE.
module dmem_arbiter #(
  parameter int RD_LAT     = 1,
  parameter int FIXED_PRIO = 0,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic [2:0]    op0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  output logic          stall0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic [2:0]    op1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_op,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t      state_reg;
  logic        last_grant_reg;
  logic        id_reg;
  logic        we_reg;
  logic [2:0]  count_reg;

  logic          win;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic [2:0]    win_op;
  logic [DW-1:0] cap_data;

  // Winner: a lone requester, or on a conflict port 0 (fixed) / the port not granted last.
  always_comb begin
    win = req1 & ~req0;
    if (req0 && req1)
      win = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_reg;
  end

  assign win_we    = win ? we1    : we0;
  assign win_addr  = win ? addr1  : addr0;
  assign win_wdata = win ? wdata1 : wdata0;
  assign win_op    = win ? op1    : op0;
  assign cap_data  = we_reg ? '0 : mem_rdata;

  assign busy   = (state_reg != IDLE);
  assign stall0 = req0 & ~ack0 & reset_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      id_reg         <= 1'b0;
      we_reg         <= 1'b0;
      count_reg      <= '0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_op         <= '0;
      mem_we         <= 1'b0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      rdata0         <= '0;
      rdata1         <= '0;
    end else begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
      case (state_reg)
        IDLE: begin
          if (req0 || req1) begin
            id_reg         <= win;
            last_grant_reg <= win;
            we_reg         <= win_we;
            mem_addr       <= win_addr;
            mem_wdata      <= win_wdata;
            mem_op         <= win_op;
            mem_we         <= win_we;
            state_reg      <= ACCESS;
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
          if (we_reg || RD_LAT == 1) begin
            ack0      <= ~id_reg;
            ack1      <= id_reg;
            rdata0    <= id_reg ? '0 : cap_data;
            rdata1    <= id_reg ? cap_data : '0;
            state_reg <= DONE;
          end else begin
            count_reg <= 3'(RD_LAT - 1);
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          count_reg <= count_reg - 3'd1;
          // Last wait cycle: mem_rdata is valid at its end.
          if (count_reg == 3'd1) begin
            ack0      <= ~id_reg;
            ack1      <= id_reg;
            rdata0    <= id_reg ? '0 : cap_data;
            rdata1    <= id_reg ? cap_data : '0;
            state_reg <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: two handshaking requesters, a timed memory
// and a cycle-count transaction model predicting every output each cycle.
module tb_dmem_arbiter;
  localparam int RD_LAT     = 3;
  localparam int FIXED_PRIO = 0;
  localparam int NCYC       = 4000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rq [2];
  logic        rwe [2];
  logic [31:0] raddr [2];
  logic [31:0] rwdata [2];
  logic [2:0]  rop [2];
  logic        ack0, ack1, stall0, mem_we, busy;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_op;

  always #5 clock = ~clock;

  dmem_arbiter #(.RD_LAT(RD_LAT), .FIXED_PRIO(FIXED_PRIO), .AW(32), .DW(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(rq[0]), .we0(rwe[0]), .addr0(raddr[0]), .wdata0(rwdata[0]), .op0(rop[0]),
    .ack0(ack0), .rdata0(rdata0), .stall0(stall0),
    .req1(rq[1]), .we1(rwe[1]), .addr1(raddr[1]), .wdata1(rwdata[1]), .op1(rop[1]),
    .ack1(ack1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_op(mem_op), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction model: the current access is described by its grant cycle.
  bit          active;
  bit          act_port, act_we, last_grant;
  logic [31:0] act_addr, act_wdata;
  logic [2:0]  act_op;
  int          grant_cyc, ack_cyc, cyc, resets;
  logic [31:0] e_addr, e_wdata;
  logic [2:0]  e_op;
  logic [31:0] mem [8];
  bit          acked [2];

  function automatic int idx(input logic [31:0] a);
    return int'(a[4:2]);
  endfunction

  task automatic new_request(input int p, input bit force_write);
    rq[p]     = 1'b1;
    rwe[p]    = force_write ? 1'b1 : 1'($urandom_range(1));
    raddr[p]  = 32'h100 + (32'($urandom_range(7)) << 2);
    rwdata[p] = $urandom;
    rop[p]    = 3'($urandom_range(7));
  endtask

  task automatic model_reset();
    active = 0; last_grant = 1;
    e_addr = '0; e_wdata = '0; e_op = '0;
  endtask

  task automatic check_outputs();
    bit          ew, eb, ea0, ea1;
    logic [31:0] erd;
    ew  = active && act_we && cyc == grant_cyc + 1;
    eb  = active && cyc > grant_cyc;
    ea0 = active && cyc == ack_cyc && act_port == 0;
    ea1 = active && cyc == ack_cyc && act_port == 1;
    erd = act_we ? 32'h0 : mem[idx(act_addr)];
    check("mem_we", 64'(mem_we), 64'(ew));
    check("mem_addr", 64'(mem_addr), 64'(e_addr));
    check("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    check("mem_op", 64'(mem_op), 64'(e_op));
    check("busy", 64'(busy), 64'(eb));
    check("ack0", 64'(ack0), 64'(ea0));
    check("ack1", 64'(ack1), 64'(ea1));
    check("rdata0", 64'(rdata0), ea0 ? 64'(erd) : 64'h0);
    check("rdata1", 64'(rdata1), ea1 ? 64'(erd) : 64'h0);
    check("stall0", 64'(stall0), 64'(rq[0] & ~ea0));
    if (ea0 || ea1)
      $display("txn cyc=%0d port=%0d we=%0d addr=%h data=%h op=%0d latency=%0d",
               cyc, act_port, act_we, act_addr, act_we ? act_wdata : erd, act_op,
               ack_cyc - grant_cyc);
  endtask

  task automatic model_step();
    bit w;
    acked[0] = 0; acked[1] = 0;
    if (active) begin
      if (act_we && cyc == grant_cyc + 1) mem[idx(act_addr)] = act_wdata;
      if (cyc == ack_cyc) begin
        active = 0;
        acked[act_port] = 1;
      end
    end else if (rq[0] || rq[1]) begin
      if (rq[0] && rq[1]) w = (FIXED_PRIO != 0) ? 1'b0 : !last_grant;
      else w = rq[1];
      active = 1; act_port = w; last_grant = w;
      act_we = rwe[w]; act_addr = raddr[w]; act_wdata = rwdata[w]; act_op = rop[w];
      grant_cyc = cyc;
      ack_cyc = cyc + (act_we ? 2 : 1 + RD_LAT);
      e_addr = act_addr; e_wdata = act_wdata; e_op = act_op;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_mem_we", 64'(mem_we), 64'h0);
    check("rst_mem_addr", 64'(mem_addr), 64'h0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'h0);
    check("rst_mem_op", 64'(mem_op), 64'h0);
    check("rst_ack0", 64'(ack0), 64'h0);
    check("rst_ack1", 64'(ack1), 64'h0);
    check("rst_rdata0", 64'(rdata0), 64'h0);
    check("rst_rdata1", 64'(rdata1), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_stall0", 64'(stall0), 64'h0);
    $display("reset cyc=%0d abandoning port=%0d we=%0d", cyc, act_port, act_we);
    model_reset();
    rq[0] = 1'b0; rq[1] = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    cyc++;
    // Simultaneous requests right after reset: port 0 must win.
    new_request(0, 1'b0);
    new_request(1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = $urandom;
    for (int p = 0; p < 2; p++) begin
      rq[p] = 0; rwe[p] = 0; raddr[p] = '0; rwdata[p] = '0; rop[p] = '0;
    end
    mem_rdata = '0;
    cyc = 0; resets = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("init_busy", 64'(busy), 64'h0);
    check("init_ack0", 64'(ack0), 64'h0);
    check("init_mem_addr", 64'(mem_addr), 64'h0);
    reset_n = 1'b1;
    new_request(0, 1'b1);
    new_request(1, 1'b1);

    for (int n = 0; n < NCYC; n++) begin
      // Memory data is only meaningful in the last cycle of a read.
      if (active && !act_we && cyc == grant_cyc + RD_LAT) mem_rdata = mem[idx(act_addr)];
      else mem_rdata = $urandom;
      @(negedge clock);
      check_outputs();
      @(posedge clock);
      model_step();
      cyc++;
      #1;
      if (active && act_port == 1 && !act_we && cyc >= grant_cyc + 2 && cyc < ack_cyc &&
          resets < 6 && $urandom_range(3) == 0) begin
        resets++;
        do_reset();
      end else if (cyc > 40 && $urandom_range(499) == 0) begin
        do_reset();
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (acked[p]) begin
            if (cyc < 14) new_request(p, 1'b1);
            else if ($urandom_range(1) == 1) new_request(p, 1'b0);
            else rq[p] = 1'b0;
          end else if (rq[p]) begin
            if (cyc >= 14 && active && act_port == p && $urandom_range(2) == 0) begin
              raddr[p] = $urandom; rwdata[p] = $urandom;
              rwe[p] = 1'($urandom_range(1)); rop[p] = 3'($urandom_range(7));
            end
          end else if ($urandom_range(2) == 0) begin
            new_request(p, 1'b0);
          end
        end
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
